netlist_record_parser: RTL

NETLIST_RECORD_PARSER -- requirements
Module: netlist_record_parser

---
 rtl/netlist_pkg.sv | 17 +
 rtl/net_fanout_table.sv | 19 +
 rtl/netlist_record_parser.sv | 130 +++++++++++++
 3 files changed

// File: rtl/netlist_pkg.sv
// netlist_pkg: record type/state enums, header field positions, pin-count legality function
package netlist_pkg;
  typedef enum logic [3:0] {
    T_VSRC = 4'd0, T_ISRC = 4'd1, T_RES = 4'd2, T_CAP = 4'd3, T_IND = 4'd4,
    T_DIODE = 4'd5, T_BJT = 4'd6, T_MOS = 4'd7, T_SUBCKT = 4'd8, T_END = 4'd15
  } comp_type_e;
  typedef enum logic [2:0] {S_CLEAR, S_HDR, S_PINS, S_REPORT, S_DONE} state_e;
  localparam int HDR_TYPE_LSB = 12;
  localparam int HDR_PC_LSB = 8;
  localparam int HDR_REF_LSB = 0;
  function automatic logic pins_ok(input logic [3:0] t, input logic [3:0] pc, input int max_pins);
    return t <= 4'(T_DIODE) ? pc == 4'd2 :
           t == 4'(T_BJT) ? pc == 4'd3 :
           t == 4'(T_MOS) ? pc == 4'd4 :
           t == 4'(T_SUBCKT) ? (pc != 4'd0 && int'(pc) <= max_pins) : 1'b0;
  endfunction
endpackage

// File: rtl/net_fanout_table.sv
// net_fanout_table: NUM_NETS x 3-bit saturating fanout counters; clear/increment RMW port (wr_*), registered scan read port (rd_*)
module net_fanout_table #(
  parameter int NUM_NETS = 64,
  parameter int NET_W = $clog2(NUM_NETS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_clr,
  input  logic [NET_W-1:0] wr_addr,
  input  logic             rd_en,
  input  logic [NET_W-1:0] rd_addr,
  output logic [2:0]       rd_data
);
  logic [2:0] mem [NUM_NETS];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_clr ? 3'd0 : mem[wr_addr] == 3'd7 ? 3'd7 : mem[wr_addr] + 3'd1;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/netlist_record_parser.sv
// netlist_record_parser: parses header/pin words (s_*), reports records (rec_*), floating nets (flt_*), done and err_count
module netlist_record_parser
  import netlist_pkg::*;
#(
  parameter int NUM_NETS = 64,
  parameter int MAX_PINS = 8,
  localparam int NET_W = $clog2(NUM_NETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  output logic             rec_valid,
  output logic [3:0]       rec_type,
  output logic [7:0]       rec_refdes,
  output logic             rec_err,
  output logic             flt_valid,
  input  logic             flt_ready,
  output logic [NET_W-1:0] flt_net,
  output logic             done,
  output logic [7:0]       err_count
);
  localparam logic [NET_W:0] N_END = (NET_W+1)'(NUM_NETS);
  state_e state, state_n;
  logic [NET_W-1:0] clr_idx, addr_q, net, wr_addr;
  logic [NET_W:0] scan_idx;
  logic [3:0] pin_cnt, pin_idx, h_type, h_pc;
  logic [7:0] h_ref;
  logic [2:0] rd_data;
  logic bad, perr, vld_q, wr_en, wr_clr, rd_en, fire, pin_bad, last, advance, scan_live, fin, fin_err, is_end;
  assign fire = s_valid && s_ready;
  assign h_type = s_data[HDR_TYPE_LSB +: 4];
  assign h_pc = s_data[HDR_PC_LSB +: 4];
  assign h_ref = s_data[HDR_REF_LSB +: 8];
  assign is_end = h_type == 4'(T_END);
  assign net = s_data[NET_W-1:0];
  assign pin_bad = s_data[15:NET_W] != '0 || {1'b0, net} >= N_END;
  assign last = pin_idx == pin_cnt - 4'd1;
  assign advance = !flt_valid || flt_ready;
  assign scan_live = scan_idx < N_END;
  assign fin = fire && (state == S_HDR ? !is_end && h_pc == 4'd0 : state == S_PINS && last);
  assign fin_err = state == S_HDR || bad || perr || pin_bad;
  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    wr_en = 1'b0;
    wr_clr = 1'b0;
    wr_addr = clr_idx;
    rd_en = 1'b0;
    case (state)
      S_CLEAR: begin
        wr_en = 1'b1;
        wr_clr = 1'b1;
        state_n = clr_idx == NET_W'(NUM_NETS - 1) ? S_HDR : S_CLEAR;
      end
      S_HDR: begin
        s_ready = 1'b1;
        state_n = !fire ? S_HDR : is_end ? S_REPORT : h_pc != 4'd0 ? S_PINS : S_HDR;
      end
      S_PINS: begin
        s_ready = 1'b1;
        wr_addr = net;
        wr_en = fire && !bad && !pin_bad;
        state_n = fire && last ? S_HDR : S_PINS;
      end
      S_REPORT: begin
        rd_en = advance && scan_live;
        state_n = advance && !scan_live && !vld_q ? S_DONE : S_REPORT;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? S_CLEAR : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= '0;
      rec_valid <= 1'b0;
      rec_err <= 1'b0;
      rec_type <= '0;
      rec_refdes <= '0;
      flt_valid <= 1'b0;
      flt_net <= '0;
      done <= 1'b0;
      err_count <= '0;
      pin_cnt <= '0;
      pin_idx <= '0;
      bad <= 1'b0;
      perr <= 1'b0;
      scan_idx <= '0;
      vld_q <= 1'b0;
      addr_q <= '0;
    end else begin
      rec_valid <= fin;
      if (fin) rec_err <= fin_err;
      if (fin && fin_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (state == S_CLEAR) clr_idx <= clr_idx + NET_W'(1);
      if (state == S_HDR && fire && !is_end) begin
        rec_type <= h_type;
        rec_refdes <= h_ref;
        pin_cnt <= h_pc;
        pin_idx <= '0;
        perr <= 1'b0;
        bad <= !pins_ok(h_type, h_pc, MAX_PINS);
      end
      if (state == S_PINS && fire) begin
        pin_idx <= pin_idx + 4'd1;
        perr <= perr | pin_bad;
      end
      // vld_q/addr_q track the entry whose data appears on rd_data one cycle after the read
      if (state == S_REPORT && advance) begin
        scan_idx <= scan_idx + (NET_W+1)'(scan_live);
        vld_q <= scan_live;
        addr_q <= scan_idx[NET_W-1:0];
        flt_valid <= vld_q && rd_data == 3'd1;
        if (vld_q && rd_data == 3'd1) flt_net <= addr_q;
      end
      if (state_n == S_DONE) done <= 1'b1;
    end
  end
  net_fanout_table #(.NUM_NETS(NUM_NETS), .NET_W(NET_W)) u_table (
    .clk(clk),
    .wr_en(wr_en),
    .wr_clr(wr_clr),
    .wr_addr(wr_addr),
    .rd_en(rd_en),
    .rd_addr(scan_idx[NET_W-1:0]),
    .rd_data(rd_data)
  );
endmodule
